// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if
// Entry/exit handshake bundle for pipe_stage_chain.
//   in_valid/in_ready/in_data/in_rd/in_we       : entry offered to stage 0
//   out_valid/out_ready/out_data/out_rd/out_we  : entry leaving the oldest stage
// master : producer/consumer side (decode feeding in, writeback taking out)
// slave  : the pipeline chain itself
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int RIDX  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [RIDX-1:0]  in_rd;
  logic             in_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [RIDX-1:0]  out_rd;
  logic             out_we;

  modport master (
    output in_valid, in_data, in_rd, in_we, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_we
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_we, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_we
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// Elastic DEPTH-stage register chain carrying a WIDTH-bit payload plus a
// destination-register tag and write enable. Stage 0 is youngest, stage
// DEPTH-1 oldest. Supports global stall, partial flush of the youngest
// stages, bubble collapse and two register-forwarding lookups.
// Optional feature: define PIPE_STAGE_PERF_EN to build the saturating
// stall-cycle and killed-entry counters; otherwise both read as 0.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   bus (slave)         entry/exit handshake bundle
//   stall_i             global hold, nothing moves
//   flush_i, flush_cnt  kill the youngest flush_cnt stages (wins over stall)
//   fwd_rs1/2           forwarding query indices
//   fwd_hit1/2, fwd_data1/2  youngest valid in-flight writer matching query
//   perf_stall, perf_flush   performance counters
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int RIDX  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pipe_stage_chain_if.slave          bus,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [$clog2(DEPTH+1)-1:0] flush_cnt,
  input  logic [RIDX-1:0]            fwd_rs1,
  input  logic [RIDX-1:0]            fwd_rs2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [WIDTH-1:0]           fwd_data1,
  output logic [WIDTH-1:0]           fwd_data2,
  output logic [31:0]                perf_stall,
  output logic [31:0]                perf_flush
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] we_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [RIDX-1:0]  rd_q   [DEPTH];

  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] kill;
  logic             move_en;
  logic             in_ready_int;
  logic             in_fire;

  // A stage can load when it, or anything older, has room or the oldest
  // entry leaves: acc[k] = !v[k] | acc[k+1], flattened to avoid a
  // combinational chain through one vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign acc[k]  = bus.out_ready | ~(&v_q[DEPTH-1:k]);
    assign kill[k] = (CW'(k) < flush_cnt);
  end

  assign move_en      = ~stall_i & ~flush_i;
  assign in_ready_int = rst_n & acc[0] & move_en;
  assign in_fire      = bus.in_valid & in_ready_int;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = rst_n & v_q[DEPTH-1] & move_en;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.out_rd    = rd_q[DEPTH-1];
  assign bus.out_we    = we_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q  <= '0;
      we_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        rd_q[k]   <= '0;
      end
    end else if (flush_i) begin
      v_q <= v_q & ~kill;
    end else if (!stall_i) begin
      if (acc[0]) begin
        v_q[0] <= in_fire;
        if (in_fire) begin
          data_q[0] <= bus.in_data;
          rd_q[0]   <= bus.in_rd;
          we_q[0]   <= bus.in_we;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (acc[k]) begin
          v_q[k] <= v_q[k-1];
          // Payload only follows a real entry; a bubble keeps stale data.
          if (v_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            rd_q[k]   <= rd_q[k-1];
            we_q[k]   <= we_q[k-1];
          end
        end
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the one that sticks.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (v_q[k] && we_q[k] && rd_q[k] == fwd_rs1 && fwd_rs1 != '0) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[k];
      end
      if (v_q[k] && we_q[k] && rd_q[k] == fwd_rs2 && fwd_rs2 != '0) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[k];
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   perf_stall_q;
  logic [31:0]   perf_flush_q;
  logic [CW-1:0] kill_cnt;
  logic [32:0]   flush_sum;

  always_comb begin
    kill_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v_q[k] & kill[k]) kill_cnt = kill_cnt + CW'(1);
    end
  end

  assign flush_sum = {1'b0, perf_flush_q} + 33'(kill_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (flush_i) begin
      perf_flush_q <= flush_sum[32] ? '1 : flush_sum[31:0];
    end else if (stall_i && perf_stall_q != '1) begin
      perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule
